// File: rtl/imem_boot_ctrl.sv
// Boot/run sequencer: streams a program into instruction memory, then releases and gates the core.
// Optional BOOT_CHECKSUM_EN builds a running sum of loaded words on `checksum`.
module imem_boot_ctrl #(
   parameter int unsigned AW        = 10,
   parameter int unsigned DEPTH     = 1024,
   parameter logic [31:0] HALT_INSN = 32'hFC00_0000
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load_start,
   input  logic          load_valid,
   input  logic [31:0]   load_data,
   input  logic          load_last,
   output logic          load_ready,
   output logic [AW-1:0] imem_a,
   output logic [31:0]   imem_d,
   output logic          imem_we,
   input  logic [31:0]   instruction,
   output logic          core_reset,
   output logic          core_run,
   output logic          halted,
   output logic          load_overflow,
   output logic [AW:0]   words_loaded,
   output logic [31:0]   checksum
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_FLUSH,
      S_RUN,
      S_HALT
   } state_t;

   state_t        state, state_nxt;
   logic [AW-1:0] cnt;
   logic          xfer;
   logic          start_load;
   logic          overflow_hit;

   always_comb begin
      state_nxt    = state;
      load_ready   = 1'b0;
      core_reset   = 1'b1;
      core_run     = 1'b0;
      start_load   = 1'b0;
      xfer         = 1'b0;
      overflow_hit = 1'b0;
      case (state)
         S_IDLE: begin
            if (load_start) begin
               start_load = 1'b1;
               state_nxt  = S_LOAD;
            end
         end
         S_LOAD: begin
            load_ready = 1'b1;
            xfer       = load_valid;
            if (load_valid) begin
               if (load_last) begin
                  state_nxt = S_FLUSH;
               end else if (cnt == AW'(DEPTH - 1)) begin
                  // Final slot filled without a terminator: stop accepting rather than wrap.
                  overflow_hit = 1'b1;
                  state_nxt    = S_FLUSH;
               end
            end
         end
         S_FLUSH: begin
            state_nxt = S_RUN;
         end
         S_RUN: begin
            core_reset = 1'b0;
            core_run   = 1'b1;
            if (load_start) begin
               start_load = 1'b1;
               state_nxt  = S_LOAD;
            end else if (instruction == HALT_INSN) begin
               state_nxt = S_HALT;
            end
         end
         S_HALT: begin
            core_reset = 1'b0;
            if (load_start) begin
               start_load = 1'b1;
               state_nxt  = S_LOAD;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_IDLE;
         cnt           <= '0;
         imem_a        <= '0;
         imem_d        <= '0;
         imem_we       <= 1'b0;
         halted        <= 1'b0;
         load_overflow <= 1'b0;
         words_loaded  <= '0;
      end else begin
         state   <= state_nxt;
         imem_we <= xfer;
         halted  <= (state_nxt == S_HALT);
         if (start_load) begin
            cnt           <= '0;
            words_loaded  <= '0;
            load_overflow <= 1'b0;
         end else if (xfer) begin
            imem_a       <= cnt;
            imem_d       <= load_data;
            cnt          <= cnt + AW'(1);
            words_loaded <= words_loaded + (AW+1)'(1);
            if (overflow_hit) begin
               load_overflow <= 1'b1;
            end
         end
      end
   end

`ifdef BOOT_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (reset || start_load) begin
         checksum <= '0;
      end else if (xfer) begin
         checksum <= checksum + load_data;
      end
   end
`else
   assign checksum = '0;
`endif

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Bench for imem_boot_ctrl: cycle vector table plus overflow and mid-load reset sequences;
// instruction memory writes are checked against a queue of expected {address, data}.
module tb_imem_boot_ctrl;

   localparam int unsigned AW = 10;

   logic          clk = 1'b0;
   logic          reset;
   logic          load_start;
   logic          load_valid;
   logic [31:0]   load_data;
   logic          load_last;
   logic          load_ready;
   logic [AW-1:0] imem_a;
   logic [31:0]   imem_d;
   logic          imem_we;
   logic [31:0]   instruction;
   logic          core_reset;
   logic          core_run;
   logic          halted;
   logic          load_overflow;
   logic [AW:0]   words_loaded;
   logic [31:0]   checksum;

   imem_boot_ctrl #(
      .AW(10),
      .DEPTH(1024),
      .HALT_INSN(32'hFC00_0000)
   ) dut (
      .clk(clk),
      .reset(reset),
      .load_start(load_start),
      .load_valid(load_valid),
      .load_data(load_data),
      .load_last(load_last),
      .load_ready(load_ready),
      .imem_a(imem_a),
      .imem_d(imem_d),
      .imem_we(imem_we),
      .instruction(instruction),
      .core_reset(core_reset),
      .core_run(core_run),
      .halted(halted),
      .load_overflow(load_overflow),
      .words_loaded(words_loaded),
      .checksum(checksum)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        start;
      logic        valid;
      logic [31:0] data;
      logic        last;
      logic [31:0] instr;
      logic        exp_ready;
      logic        exp_creset;
      logic        exp_crun;
      logic        exp_halted;
      int unsigned exp_wl;
   } vec_t;

   typedef struct {
      logic [AW-1:0] a;
      logic [31:0]   d;
   } wr_t;

   vec_t        tbl[20];
   wr_t         wq[$];
   int          total = 0;
   int          bad   = 0;
   logic [AW-1:0] addr_model;
   logic [31:0] sum_model;

   function automatic vec_t mk(logic s, logic v, logic [31:0] d, logic l, logic [31:0] i,
                               logic r, logic cr, logic cn, logic h, int unsigned wl);
      vec_t t;
      t.start = s; t.valid = v; t.data = d; t.last = l; t.instr = i;
      t.exp_ready = r; t.exp_creset = cr; t.exp_crun = cn; t.exp_halted = h; t.exp_wl = wl;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_sum();
`ifdef BOOT_CHECKSUM_EN
      return sum_model;
`else
      return 32'h0;
`endif
   endfunction

   // Each handshake must be followed by exactly one write, in order.
   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         if (wq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got addr %h data %h expected no write at %0t",
                     imem_a, imem_d, $time);
         end else begin
            wr_t w;
            w = wq.pop_front();
            chk("write_addr", 32'(imem_a), 32'(w.a));
            chk("write_data", imem_d, w.d);
         end
      end
   end

   // Applies one cycle of stimulus, records any expected write, then checks post-edge outputs.
   task automatic step(input vec_t v, input string tag);
      load_start  = v.start;
      load_valid  = v.valid;
      load_data   = v.data;
      load_last   = v.last;
      instruction = v.instr;
      #1;
      chk({tag, "_ready"}, 32'(load_ready), 32'(v.exp_ready));
      if (v.start) begin
         addr_model = '0;
         sum_model  = '0;
      end
      if (v.valid && v.exp_ready) begin
         wq.push_back('{a: addr_model, d: v.data});
         addr_model = addr_model + AW'(1);
         sum_model  = sum_model + v.data;
      end
      @(posedge clk);
      #1;
      chk({tag, "_core_reset"}, 32'(core_reset), 32'(v.exp_creset));
      chk({tag, "_core_run"}, 32'(core_run), 32'(v.exp_crun));
      chk({tag, "_halted"}, 32'(halted), 32'(v.exp_halted));
      chk({tag, "_words"}, 32'(words_loaded), v.exp_wl);
      chk({tag, "_checksum"}, checksum, exp_sum());
   endtask

   initial begin
      reset       = 1'b1;
      load_start  = 1'b0;
      load_valid  = 1'b0;
      load_data   = '0;
      load_last   = 1'b0;
      instruction = '0;
      addr_model  = '0;
      sum_model   = '0;

      //           st    vld   data          last  instr          rdy   crst  crun  hlt   wl
      tbl[0]  = mk(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 0);
      tbl[1]  = mk(1'b0, 1'b1, 32'h20080005, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1);
      tbl[2]  = mk(1'b0, 1'b1, 32'h20090003, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 2);
      tbl[3]  = mk(1'b0, 1'b1, 32'h01095020, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 3);
      tbl[4]  = mk(1'b0, 1'b1, 32'hFC000000, 1'b1, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 4);
      tbl[5]  = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 4);
      tbl[6]  = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h20080005, 1'b0, 1'b0, 1'b1, 1'b0, 4);
      tbl[7]  = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'hFC000000, 1'b0, 1'b0, 1'b0, 1'b1, 4);
      tbl[8]  = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 4);
      tbl[9]  = mk(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 0);
      tbl[10] = mk(1'b0, 1'b1, 32'h11111111, 1'b1, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1);
      tbl[11] = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1);
      tbl[12] = mk(1'b1, 1'b0, 32'h0,        1'b0, 32'hFC000000, 1'b0, 1'b1, 1'b0, 1'b0, 0);
      tbl[13] = mk(1'b0, 1'b1, 32'hA5A50001, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1);
      tbl[14] = mk(1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1);
      tbl[15] = mk(1'b0, 1'b1, 32'hA5A50002, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 2);
      tbl[16] = mk(1'b0, 1'b0, 32'hFFFFFFFF, 1'b1, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 2);
      tbl[17] = mk(1'b0, 1'b1, 32'hA5A50003, 1'b1, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 3);
      tbl[18] = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 3);
      tbl[19] = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'hFC000000, 1'b0, 1'b0, 1'b0, 1'b1, 3);

      repeat (3) @(posedge clk);
      #1;
      chk("rst_core_reset", 32'(core_reset), 32'd1);
      chk("rst_core_run", 32'(core_run), 32'd0);
      chk("rst_ready", 32'(load_ready), 32'd0);
      chk("rst_we", 32'(imem_we), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_overflow", 32'(load_overflow), 32'd0);
      chk("rst_imem_a", 32'(imem_a), 32'd0);
      chk("rst_imem_d", imem_d, 32'd0);
      chk("rst_words", 32'(words_loaded), 32'd0);
      chk("rst_checksum", checksum, 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 20; i++) begin
         step(tbl[i], $sformatf("vec%0d", i));
         if (i == 5) begin
`ifdef BOOT_CHECKSUM_EN
            chk("prog_checksum", checksum, 32'h3D1A5028);
`else
            chk("prog_checksum", checksum, 32'h0);
`endif
         end
      end

      // Overflow: 1025 words offered, never terminated.
      step(mk(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 0), "ovf_start");
      instruction = '0;
      for (int i = 0; i < 1024; i++) begin
         load_start = 1'b0;
         load_valid = 1'b1;
         load_data  = 32'(i) * 32'd3 + 32'h100;
         load_last  = 1'b0;
         #1;
         if (i == 0 || i == 1023) begin
            chk("ovf_ready_stream", 32'(load_ready), 32'd1);
            chk("ovf_flag_early", 32'(load_overflow), 32'd0);
         end
         wq.push_back('{a: addr_model, d: load_data});
         addr_model = addr_model + AW'(1);
         sum_model  = sum_model + load_data;
         @(posedge clk);
         #1;
      end
      load_data = 32'hDEADBEEF;
      chk("ovf_flag", 32'(load_overflow), 32'd1);
      chk("ovf_words", 32'(words_loaded), 32'd1024);
      chk("ovf_ready_flush", 32'(load_ready), 32'd0);
      chk("ovf_checksum", checksum, exp_sum());
      @(posedge clk);
      #1;
      chk("ovf_run", 32'(core_run), 32'd1);
      chk("ovf_ready_run", 32'(load_ready), 32'd0);
      chk("ovf_words_hold", 32'(words_loaded), 32'd1024);
      load_valid = 1'b0;

      // Reset after 2 of 5 words.
      step(mk(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 0), "rml_start");
      step(mk(1'b0, 1'b1, 32'h0BAD0001, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1), "rml_w0");
      step(mk(1'b0, 1'b1, 32'h0BAD0002, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 2), "rml_w1");
      load_valid = 1'b1;
      load_data  = 32'h0BAD0003;
      reset      = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rml_core_reset", 32'(core_reset), 32'd1);
      chk("rml_core_run", 32'(core_run), 32'd0);
      chk("rml_words", 32'(words_loaded), 32'd0);
      chk("rml_ready", 32'(load_ready), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("rml_idle_ready", 32'(load_ready), 32'd0);
      load_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("writes_drained", 32'(wq.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
